// File: rtl/prime_sieve_engine.sv
// prime_sieve_engine: sieve of Eratosthenes over an external 1-bit flag RAM, streaming primes on valid/ready
// Ports: clk, rstn (async active-low); start/descend begin a run and choose the scan order;
// ram_we/ram_waddr/ram_wdata write flags (1 = composite); ram_raddr/ram_rdata read flags RD_LAT cycles later;
// prime_valid/prime_ready/prime_data stream the primes; prime_count counts accepts; busy/done give run status.
module prime_sieve_engine #(
    parameter int MAX_N  = 999999,
    parameter int AW     = 20,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          descend,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic          ram_rdata,
    output logic          prime_valid,
    input  logic          prime_ready,
    output logic [AW-1:0] prime_data,
    output logic [AW-1:0] prime_count,
    output logic          busy,
    output logic          done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_OUTER = 3'd2;
    localparam logic [2:0] S_OWAIT = 3'd3;
    localparam logic [2:0] S_MARK  = 3'd4;
    localparam logic [2:0] S_SCAN  = 3'd5;
    localparam logic [2:0] S_EMIT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;
    localparam logic [AW-1:0]   MAX_A = AW'(MAX_N);
    localparam logic [AW:0]     MAX_J = (AW+1)'(MAX_N);
    localparam logic [2*AW-1:0] MAX_W = (2*AW)'(MAX_N);
    localparam logic [AW-1:0]   ONE   = AW'(1);
    localparam logic [AW-1:0]   TWO   = AW'(2);
    localparam logic [7:0]      LAT   = 8'(RD_LAT);

    logic [2:0]      state_q, state_d;
    logic            desc_q, desc_d;
    logic [AW-1:0]   i_q, i_d;
    logic [AW:0]     j_q, j_d;
    logic [AW-1:0]   k_q, k_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            wdata_q, wdata_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            valid_q, valid_d;
    logic [AW-1:0]   data_q, data_d;
    logic [AW-1:0]   count_q, count_d;
    logic [2*AW-1:0] sq;
    logic [AW:0]     jn;
    logic [AW-1:0]   k_step, k_first;
    logic            k_last, rd_ok;

    // i*i at double width so the termination test can never wrap
    assign sq      = {{AW{1'b0}}, i_q} * {{AW{1'b0}}, i_q};
    assign jn      = j_q + {1'b0, i_q};
    // "past the end" is decided on the current k, so no wider k is needed
    assign k_last  = desc_q ? (k_q == TWO) : (k_q == MAX_A);
    assign k_step  = desc_q ? k_q - ONE : k_q + ONE;
    assign k_first = desc_q ? MAX_A : TWO;
    // raddr is held from the cycle cnt was cleared, so data is valid once cnt reaches RD_LAT
    assign rd_ok   = cnt_q == LAT;

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q + 8'd1;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    desc_d  = descend;
                    count_d = '0;
                    we_d    = 1'b1;
                    wdata_d = 1'b0;
                    waddr_d = '0;
                end
            end
            S_CLEAR: begin
                if (waddr_q == MAX_A) begin
                    we_d    = 1'b0;
                    i_d     = TWO;
                    state_d = S_OUTER;
                end else begin
                    waddr_d = waddr_q + ONE;
                end
            end
            S_OUTER: begin
                cnt_d   = '0;
                raddr_d = sq > MAX_W ? k_first : i_q;
                k_d     = sq > MAX_W ? k_first : k_q;
                state_d = sq > MAX_W ? S_SCAN : S_OWAIT;
            end
            S_OWAIT: begin
                if (rd_ok && ram_rdata) begin
                    i_d     = i_q + ONE;
                    state_d = S_OUTER;
                end else if (rd_ok) begin
                    j_d     = sq[AW:0];
                    waddr_d = sq[AW-1:0];
                    we_d    = 1'b1;
                    wdata_d = 1'b1;
                    state_d = S_MARK;
                end
            end
            S_MARK: begin
                if (jn <= MAX_J) begin
                    j_d     = jn;
                    waddr_d = jn[AW-1:0];
                end else begin
                    we_d    = 1'b0;
                    i_d     = i_q + ONE;
                    state_d = S_OUTER;
                end
            end
            S_SCAN: begin
                if (rd_ok && !ram_rdata) begin
                    data_d  = k_q;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else if (rd_ok) begin
                    state_d = k_last ? S_DONE : S_SCAN;
                    k_d     = k_step;
                    raddr_d = k_step;
                    cnt_d   = '0;
                end
            end
            S_EMIT: begin
                if (prime_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + ONE;
                    state_d = k_last ? S_DONE : S_SCAN;
                    k_d     = k_step;
                    raddr_d = k_step;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            desc_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
            raddr_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign ram_we      = we_q;
    assign ram_waddr   = waddr_q;
    assign ram_wdata   = wdata_q;
    assign ram_raddr   = raddr_q;
    assign prime_valid = valid_q;
    assign prime_data  = data_q;
    assign prime_count = count_q;
    assign busy        = state_q != S_IDLE && state_q != S_DONE;
    assign done        = state_q == S_DONE;
endmodule

// File: tb/tb_prime_sieve_engine.sv
// tb_prime_sieve_engine: directed bench; lane 0 = MAX_N 30/RD_LAT 2, lane 1 = 30/3, lane 2 = 2/1
module tb_prime_sieve_engine;
    localparam int AW = 20;
    localparam logic [AW-1:0] EXP [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    rstn_v, start_v, desc_v, rdy_v, fill_v;
    logic [2:0]    we_v, wd_v, rd_v, pv_v, busy_v, done_v;
    logic [AW-1:0] wa_v [3];
    logic [AW-1:0] ra_v [3];
    logic [AW-1:0] pd_v [3];
    logic [AW-1:0] pc_v [3];
    logic          mem  [3][32];
    logic [4:0]    pipe [3][4];
    logic [AW-1:0] acc  [3][16];
    int            tacc [3][16];
    int            nacc [3];
    int            nmark [3];
    int            cyc;
    int            checks = 0;
    int            fails = 0;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int N = (g == 2) ? 2 : 30;
        localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        prime_sieve_engine #(.MAX_N(N), .AW(AW), .RD_LAT(L)) dut (
            .clk(clk), .rstn(rstn_v[g]), .start(start_v[g]), .descend(desc_v[g]),
            .ram_we(we_v[g]), .ram_waddr(wa_v[g]), .ram_wdata(wd_v[g]),
            .ram_raddr(ra_v[g]), .ram_rdata(rd_v[g]),
            .prime_valid(pv_v[g]), .prime_ready(rdy_v[g]), .prime_data(pd_v[g]),
            .prime_count(pc_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );
        assign rd_v[g] = mem[g][pipe[g][L-1]];
    end

    // flag RAM models plus accept / mark-write recorders
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 3; g++) begin
            if (fill_v[g]) begin
                for (int a = 0; a < 32; a++) mem[g][a] <= 1'b1;
            end else if (we_v[g]) begin
                mem[g][wa_v[g][4:0]] <= wd_v[g];
            end
            pipe[g][0] <= ra_v[g][4:0];
            for (int m = 1; m < 4; m++) pipe[g][m] <= pipe[g][m-1];
            if (start_v[g] && !busy_v[g]) begin
                nacc[g]  <= 0;
                nmark[g] <= 0;
            end else begin
                if (pv_v[g] && rdy_v[g] && nacc[g] < 16) begin
                    acc[g][nacc[g][3:0]]  <= pd_v[g];
                    tacc[g][nacc[g][3:0]] <= cyc;
                    nacc[g]               <= nacc[g] + 1;
                end
                if (we_v[g] && wd_v[g]) nmark[g] <= nmark[g] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int g);
        return {23'd0, we_v[g], wd_v[g], |wa_v[g], |ra_v[g], pv_v[g], |pd_v[g], |pc_v[g], busy_v[g], done_v[g]};
    endfunction

    task automatic chk_stream(input int g, input bit desc, input int n);
        chk($sformatf("lane%0d_naccept", g), nacc[g], n);
        for (int i = 0; i < n; i++)
            chk($sformatf("lane%0d_prime%0d", g, i), 32'(acc[g][i]), 32'(desc ? EXP[n-1-i] : EXP[i]));
    endtask

    task automatic wait_done(input int g);
        int t = 0;
        while (!done_v[g] && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("lane%0d_done", g), done_v[g], 1);
    endtask

    task automatic wait_mark(input int g);
        int t = 0;
        while (!(we_v[g] && wd_v[g]) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("mark_seen", we_v[g] && wd_v[g], 1);
    endtask

    task automatic pulse_start(input int g, input bit desc);
        desc_v[g]  = desc;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    initial begin
        logic [31:0] got_m, exp_m;
        int bad, t;
        bit stable;
        rstn_v  = '1;
        start_v = '0;
        desc_v  = '0;
        rdy_v   = '1;
        fill_v  = '0;
        #1 rstn_v = '0;
        #1;
        chk("reset_outs_l0", outs(0), 0);
        chk("reset_outs_l2", outs(2), 0);
        repeat (2) @(negedge clk);
        rstn_v = '1;
        @(negedge clk);
        fill_v[0] = 1'b1;
        @(negedge clk);
        fill_v = '0;
        desc_v = '0;
        start_v = '1;
        @(negedge clk);
        start_v = '0;
        bad = 0;
        for (int c = 0; c <= 30; c++) begin
            if (!(we_v[0] && !wd_v[0] && wa_v[0] == AW'(c))) bad++;
            @(negedge clk);
        end
        chk("clear_writes_bad", bad, 0);
        chk("clear_end_we", we_v[0], 0);
        wait_mark(0);
        pulse_start(0, 1'b1);
        chk("start_in_mark_busy", busy_v[0], 1);
        t = 0;
        while (!(pv_v[0] && pd_v[0] == 11) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("prime11_seen", 32'(pd_v[0]), 11);
        rdy_v[0] = 1'b0;
        chk("count_before_bp", 32'(pc_v[0]), 4);
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            stable &= pv_v[0] && pd_v[0] == 11 && pc_v[0] == 4;
        end
        chk("bp_stable", stable, 1);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_count", 32'(pc_v[0]), 5);
        chk("bp_valid_drop", pv_v[0], 0);
        wait_done(0);
        wait_done(1);
        wait_done(2);
        chk_stream(0, 1'b0, 10);
        chk("l0_count", 32'(pc_v[0]), 10);
        chk("l0_busy_done", busy_v[0], 0);
        chk("l0_we_idle", we_v[0], 0);
        chk("l0_gap_2_3", tacc[0][1] - tacc[0][0], 4);
        chk("l0_gap_3_5", tacc[0][2] - tacc[0][1], 7);
        got_m = '0;
        exp_m = 32'h7FFF_FFFC;
        for (int x = 0; x < 31; x++) got_m[x] = mem[0][x];
        for (int p = 0; p < 10; p++) exp_m[EXP[p][4:0]] = 1'b0;
        chk("ram_flags", got_m, exp_m);
        chk_stream(1, 1'b0, 10);
        chk("l1_count", 32'(pc_v[1]), 10);
        chk("l1_gap_2_3", tacc[1][1] - tacc[1][0], 5);
        chk_stream(2, 1'b0, 1);
        chk("l2_count", 32'(pc_v[2]), 1);
        chk("l2_mark_writes", nmark[2], 0);
        repeat (3) @(negedge clk);
        chk("l0_count_hold", 32'(pc_v[0]), 10);
        pulse_start(0, 1'b1);
        chk("done_drop", done_v[0], 0);
        chk("count_zeroed", 32'(pc_v[0]), 0);
        wait_done(0);
        chk_stream(0, 1'b1, 10);
        chk("l0_desc_count", 32'(pc_v[0]), 10);
        pulse_start(0, 1'b0);
        wait_mark(0);
        rstn_v[0] = 1'b0;
        #1;
        chk("midrun_reset_outs", outs(0), 0);
        @(negedge clk);
        rstn_v[0] = 1'b1;
        @(negedge clk);
        pulse_start(0, 1'b0);
        wait_done(0);
        chk_stream(0, 1'b0, 10);
        chk("l0_after_reset_count", 32'(pc_v[0]), 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
